// File: rtl/restoring_divider_pkg.sv
// Shared definitions for the sequential restoring divider: controller
// state encoding, default operand width and iteration-counter sizing.
package restoring_divider_pkg;

    // Default operand width; the divider supports any W >= 2.
    localparam int DEFAULT_W = 4;

    // Controller states. The encodings are fixed so that other blocks
    // watching the state bus agree on them.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width of the iteration counter. It counts down from W-1 to 0,
    // so clog2(W) bits are always enough.
    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/restoring_divider_add_sub.sv
// Combinational add/subtract unit, shared in form with the arithmetic
// block's add/sub datapath. t_i=1 adds and t_i=0 subtracts. When
// subtracting, c_o is the borrow out (1 when a_i < b_i).
module add_sub_unit #(
    parameter int W = 5
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         t_i,
    output logic [W-1:0] s_o,
    output logic         c_o
);

    // Single (W+1)-bit add or subtract; the top bit is carry/borrow.
    always_comb begin
        if (t_i) begin
            {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i};
        end else begin
            {c_o, s_o} = {1'b0, a_i} - {1'b0, b_i};
        end
    end

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider. It produces one quotient bit per
// clock by trial-subtracting the divisor from the shifted partial
// remainder, and restores the partial remainder when the trial borrows.
// A controller drives it through a start/busy/done handshake.
module restoring_divider
    import restoring_divider_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CNT_W = cnt_width(W);

    // Controller and datapath state.
    state_e         state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [W:0]     p_q;          // partial remainder, one bit wider than W
    logic [W-1:0]   q_q;          // dividend shifting out / quotient shifting in
    logic [W-1:0]   divisor_q;    // divisor captured at acceptance
    logic           dz_q;         // captured divisor was zero

    // Registered outputs.
    logic           busy_q;
    logic           done_q;
    logic [W-1:0]   quotient_q;
    logic [W-1:0]   remainder_q;
    logic           div_by_zero_q;

    // One-iteration datapath.
    logic [2*W:0]   pq_shift;
    logic [W:0]     p_shift;
    logic [W-1:0]   q_shift;
    logic [W:0]     trial;
    logic           borrow;
    logic [W:0]     p_d;
    logic [W-1:0]   q_d;

    // The trial subtract is P_shifted - {0, divisor}. A borrow means the
    // divisor does not fit, so the shifted value is kept.
    add_sub_unit #(
        .W (W + 1)
    ) u_trial_sub (
        .a_i (p_shift),
        .b_i ({1'b0, divisor_q}),
        .t_i (1'b0),
        .s_o (trial),
        .c_o (borrow)
    );

    // Shift {P,Q} left by one, then pick the restored or subtracted remainder
    // and set the new quotient bit.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
        pq_shift = {p_q, q_q} << 1;
        p_shift  = pq_shift[2*W:W];
        q_shift  = pq_shift[W-1:0];
        p_d      = borrow ? p_shift : trial;
        q_d      = q_shift | {{(W-1){1'b0}}, ~borrow};
    end

    // Controller: sequences IDLE -> CALC -> DONE -> IDLE and owns all registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the operand and shift registers are reset as well, so an op
            // that reset interrupts leaves no stale state behind.
            state_q       <= IDLE;
            cnt_q         <= '0;
            p_q           <= '0;
            q_q           <= '0;
            divisor_q     <= '0;
            dz_q          <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here, so every register samples
            // pre-edge values no matter what order the statements are in.
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (start) begin
                        divisor_q     <= divisor;
                        busy_q        <= 1'b1;
                        div_by_zero_q <= 1'b0;
                        cnt_q         <= CNT_W'(W - 1);
                        if (divisor == '0) begin
                            // No iterations: load the fixed /0 result directly.
                            q_q     <= '1;
                            p_q     <= {1'b0, dividend};
                            dz_q    <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            q_q     <= dividend;
                            p_q     <= '0;
                            dz_q    <= 1'b0;
                            state_q <= CALC;
                        end
                    end
                end

                CALC: begin
                    p_q <= p_d;
                    q_q <= q_d;
                    if (cnt_q == '0) begin
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                DONE: begin
                    // Publish results; done pulses during the following IDLE cycle.
                    done_q        <= 1'b1;
                    quotient_q    <= q_q;
                    remainder_q   <= p_q[W-1:0];
                    div_by_zero_q <= dz_q;
                    state_q       <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider at W=4. It uses directed vectors
// with hand-computed results, then runs every divisor/dividend pair with
// start held high.
module tb_restoring_divider;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int n_checks = 0;
    int n_errors = 0;

    restoring_divider #(
        .W (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Start one op from IDLE and wait for done (bounded). Then check the
    // latency, the results, and that done is a single pulse.
    task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input int exp_lat, input logic [3:0] exp_q,
                          input logic [3:0] exp_r, input logic exp_dz);
        int lat;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        check({tag, " busy_after_accept"}, busy, 1);
        lat = 0;
        while (lat < 20 && !done) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " quotient"}, quotient, exp_q);
        check({tag, " remainder"}, remainder, exp_r);
        check({tag, " div_by_zero"}, div_by_zero, exp_dz);
        check({tag, " busy_in_done"}, busy, 1);
        @(posedge clk);
        #1;
        check({tag, " done_cleared"}, done, 0);
        check({tag, " busy_cleared"}, busy, 0);
        check({tag, " quotient_held"}, quotient, exp_q);
        check({tag, " remainder_held"}, remainder, exp_r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_count;
        int done_at;
        int pairs[$];
        int waited;
        int hold_bad;
        int a;
        int b;
        logic [3:0] prev_q;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 4'd0;
        divisor  = 4'd0;
        #1;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset quotient", quotient, 0);
        check("reset remainder", remainder, 0);
        check("reset dz", div_by_zero, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic directed division vectors.
        run_op("13/4", 4'd13, 4'd4, 5, 4'd3, 4'd1, 1'b0);
        run_op("15/1", 4'd15, 4'd1, 5, 4'd15, 4'd0, 1'b0);
        run_op("3/7", 4'd3, 4'd7, 5, 4'd0, 4'd3, 1'b0);
        run_op("7/7", 4'd7, 4'd7, 5, 4'd1, 4'd0, 1'b0);
        run_op("9/0", 4'd9, 4'd0, 1, 4'hF, 4'd9, 1'b1);
        run_op("15/15", 4'd15, 4'd15, 5, 4'd1, 4'd0, 1'b0);

        // start pulses during CALC and DONE must be ignored.
        @(negedge clk);
        dividend = 4'd13;
        divisor  = 4'd4;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        done_count = 0;
        done_at    = -1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                done_count++;
                done_at = i;
                check("ignore quotient", quotient, 3);
                check("ignore remainder", remainder, 1);
            end
            dividend = 4'd15;
            divisor  = 4'd1;
            start    = (i == 1 || i == 4);
        end
        start = 1'b0;
        check("ignore done_count", done_count, 1);
        check("ignore done_at", done_at, 5);
        check("ignore busy_end", busy, 0);

        // Reset asserted mid-operation clears the outputs immediately.
        @(negedge clk);
        dividend = 4'd14;
        divisor  = 4'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset busy", busy, 0);
        check("midreset done", done, 0);
        check("midreset quotient", quotient, 0);
        check("midreset remainder", remainder, 0);
        check("midreset dz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("postreset idle busy", busy, 0);
        run_op("14/3", 4'd14, 4'd3, 5, 4'd4, 4'd2, 1'b0);

        // Exhaustive pairs with start held high, in shuffled order.
        for (int x = 0; x < 16; x++)
            for (int y = 1; y < 16; y++)
                pairs.push_back(x * 16 + y);
        for (int i = pairs.size() - 1; i > 0; i--) begin
            int j;
            int tmp;
            j        = $urandom_range(i, 0);
            tmp      = pairs[i];
            pairs[i] = pairs[j];
            pairs[j] = tmp;
        end

        @(negedge clk);
        dividend = 4'(pairs[0] / 16);
        divisor  = 4'(pairs[0] % 16);
        start    = 1'b1;
        prev_q   = quotient;
        for (int k = 0; k < pairs.size(); k++) begin
            a        = pairs[k] / 16;
            b        = pairs[k] % 16;
            waited   = 0;
            hold_bad = 0;
            do begin
                @(posedge clk);
                #1;
                waited++;
                if (!done && quotient !== prev_q) hold_bad = 1;
            end while (!done && waited < 20);
            check("sweep spacing", waited, 6);
            check("sweep hold", hold_bad, 0);
            check("sweep quotient", quotient, a / b);
            check("sweep remainder", remainder, a % b);
            check("sweep dz", div_by_zero, 0);
            prev_q = 4'(a / b);
            if (k + 1 < pairs.size()) begin
                dividend = 4'(pairs[k + 1] / 16);
                divisor  = 4'(pairs[k + 1] % 16);
            end else begin
                start = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check("sweep end busy", busy, 0);
        check("sweep end done", done, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
